disp_scan_ctrl: RTL and testbench
=================================

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high; all state SHALL change only on the rising edge of clk.
REQ-002 Parameter REFRESH_DIV, default 100000, SHALL set the number of clk cycles per digit scan slot (minimum 2).
REQ-003 Parameter ERR_CYCLES, default 200000000, SHALL set the number of clk cycles the error display is held (minimum 1).
REQ-004 Port clk, input, width 1: system clock.
REQ-005 Port reset, input, width 1: synchronous active-high reset.
REQ-006 Port key_valid, input, width 1: one-cycle strobe meaning key_val holds a new keypad digit.
REQ-007 Port key_val, input, width 4: digit value; only 0-9 are legal.
REQ-008 Port clear, input, width 1: one-cycle strobe that discards the entry.
REQ-009 Port err, input, width 1: one-cycle strobe requesting the error display.
REQ-010 Port press_count, output, width 3: number of digits stored, 0-4.
REQ-011 Port busy_err, output, width 1: high while in ERROR.
REQ-012 Port anode, output, width 4: active-low digit enables; anode[3] is the leftmost digit.
REQ-013 Port segOut, output, width 7: active-low segments {g,f,e,d,c,b,a}.

Function
REQ-014 The FSM SHALL have the states IDLE, ENTRY and ERROR.
REQ-015 key_valid with key_val<=9 in IDLE or ENTRY SHALL store the value in buf[press_count], increment press_count and select ENTRY; key_val>9 SHALL be ignored.
REQ-016 key_valid with press_count==4 SHALL be ignored: the buffer and count stay unchanged and no wrap occurs.
REQ-017 clear SHALL zero press_count and all buf entries and go to IDLE on the next edge from any state.
REQ-018 err in IDLE or ENTRY SHALL go to ERROR, zero press_count and buf, and load the error timer with ERR_CYCLES-1.
REQ-019 In ERROR the timer SHALL decrement each cycle and go to IDLE on the cycle after it reads 0; key_valid SHALL be ignored, and a further err SHALL NOT reload the timer.
REQ-020 Priority on simultaneous strobes SHALL be clear > err > key_valid.
REQ-021 The prescaler SHALL count 0..REFRESH_DIV-1 continuously in every state; at its terminal count, scan index idx (2 bits) SHALL advance 0,1,2,3,0.
REQ-022 anode and segOut SHALL be registered and reflect idx with one cycle of latency.
REQ-023 IDLE: anode=4'b1111 and segOut=7'b1111111.
REQ-024 ENTRY: if idx<press_count, anode SHALL drive bit (3-idx) low only and segOut=decode(buf[idx]); otherwise anode=4'b1111 and segOut=7'b1111111.
REQ-025 ERROR: anode SHALL drive bit (3-idx) low only and segOut=decode(4'hA)=7'b0001001.
REQ-026 Decode SHALL be 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001001; all other codes SHALL give 1111111.
REQ-027 busy_err SHALL be registered and high exactly while the state is ERROR.

Reset
REQ-028 Reset SHALL set: state=IDLE, press_count=0, buf all 0, prescaler=0, idx=0, error timer=0, anode=4'b1111, segOut=7'b1111111, busy_err=0.
REQ-029 Reset SHALL override all strobes on the same cycle, including a reset mid-ERROR or mid-entry.

Configuration
REQ-030 With DISP_BLINK_EN defined, a blink bit SHALL toggle every 256 scan-index advances in ERROR (cleared on ERROR entry); while the bit is 1, the outputs SHALL be anode=4'b1111 and segOut=7'b1111111.
REQ-031 Without DISP_BLINK_EN, the ERROR display SHALL be steady and no blink logic SHALL be present.

Structure
REQ-032 The shared package SHALL hold the state encoding (IDLE=0, ENTRY=1, ERROR=2), the blank pattern 7'b1111111, the blank anode 4'b1111 and the error code 4'hA.
REQ-033 Decode SHALL be a combinational sub-module named seven_seg_decode, instantiated once and fed the mux-selected code.

Verification (REQ-034..039: bench SHALL cover; REFRESH_DIV=4, ERR_CYCLES=50)
REQ-034 Reset then keys 1,2,3 -> press_count=3; over 16 cycles anode cycles 0111,1011,1101,1111 with segOut 1111001,0100100,0110000,1111111.
REQ-035 Five keys 9,8,7,6,5 -> press_count=4; the fifth key is ignored and buf[3]=6.
REQ-036 key 4 then key_val=4'hC -> press_count stays 1.
REQ-037 err then wait -> busy_err high 50 cycles, all slots show 0001001, then IDLE with anode=1111.
REQ-038 clear, err and key_valid on the same cycle -> IDLE, press_count=0, busy_err=0.
REQ-039 Reset asserted mid-ERROR -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/disp_scan_ctrl_pkg.sv
// Shared definitions for the keypad-entry display scanner.
// Holds the FSM encoding, digit/segment widths, blank patterns, the error
// glyph code and a helper that builds the one-hot-low anode for a slot.
package disp_scan_ctrl_pkg;

    localparam int unsigned DIGITS  = 4;
    localparam int unsigned CODE_W  = 4;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned BLINK_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    localparam logic [SEG_W-1:0]  BLANK_SEG = 7'b1111111;
    localparam logic [DIGITS-1:0] BLANK_AN  = 4'b1111;
    localparam logic [CODE_W-1:0] ERR_CODE  = 4'hA;

    // Slot 0 is the leftmost digit, driven by anode[3].
    function automatic logic [DIGITS-1:0] anode_sel(input logic [IDX_W-1:0] idx);
        logic [DIGITS-1:0] an;
        an = BLANK_AN;
        an[IDX_W'(DIGITS-1) - idx] = 1'b0;
        return an;
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_decode.sv
// Seven-segment decoder (combinational), active-low {g,f,e,d,c,b,a}.
// Ports: code  - 4-bit digit code (0-9 digits, A = error glyph)
//        seg_c - active-low segment pattern; unknown codes are blank
module seven_seg_decode
    import disp_scan_ctrl_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [SEG_W-1:0]  seg_c
);

    always_comb begin
        seg_c = BLANK_SEG;
        case (code)
            4'h0: seg_c = 7'b1000000;
            4'h1: seg_c = 7'b1111001;
            4'h2: seg_c = 7'b0100100;
            4'h3: seg_c = 7'b0110000;
            4'h4: seg_c = 7'b0011001;
            4'h5: seg_c = 7'b0010010;
            4'h6: seg_c = 7'b0000010;
            4'h7: seg_c = 7'b1111000;
            4'h8: seg_c = 7'b0000000;
            4'h9: seg_c = 7'b0010000;
            4'hA: seg_c = 7'b0001001;
            default: seg_c = BLANK_SEG;
        endcase
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Keypad digit entry with a 4-digit multiplexed seven-segment display.
// Stores up to four keyed digits, scans them onto the display and shows a
// timed error glyph on request.
// Parameters: REFRESH_DIV - clk cycles per scan slot (>= 2)
//             ERR_CYCLES  - clk cycles the error display is held (>= 1)
// Ports: clk, reset (sync, active-high)
//        key_valid/key_val - new keypad digit strobe and value
//        clear             - discard entry strobe
//        err               - error display request strobe
//        press_count       - digits stored (0-4)
//        busy_err          - high while in ERROR
//        anode             - active-low digit enables, anode[3] leftmost
//        segOut            - active-low segments {g,f,e,d,c,b,a}
// Build option: define DISP_BLINK_EN to blink the error display.
module disp_scan_ctrl
    import disp_scan_ctrl_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned ERR_CYCLES  = 200000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_valid,
    input  logic [CODE_W-1:0] key_val,
    input  logic              clear,
    input  logic              err,
    output logic [CNT_W-1:0]  press_count,
    output logic              busy_err,
    output logic [DIGITS-1:0] anode,
    output logic [SEG_W-1:0]  segOut
);

    localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned TMR_W = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ERR_CYCLES - 1);

    state_t                          state;
    state_t                          state_next;
    logic [CNT_W-1:0]                cnt_next;
    logic [DIGITS-1:0][CODE_W-1:0]   digit_buf;
    logic [DIGITS-1:0][CODE_W-1:0]   buf_next;
    logic [TMR_W-1:0]                timer;
    logic [TMR_W-1:0]                timer_next;
    logic [PRE_W-1:0]                presc;
    logic [IDX_W-1:0]                idx;
    logic                            scan_tick_c;
    logic [CODE_W-1:0]               code_sel_c;
    logic [SEG_W-1:0]                seg_dec_c;
    logic [DIGITS-1:0]               anode_next;
    logic [SEG_W-1:0]                seg_next;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next state and entry/timer updates; clear > err > key_valid
    always_comb begin
        state_next = state;
        cnt_next   = press_count;
        buf_next   = digit_buf;
        timer_next = timer;
        if (clear) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            buf_next   = '0;
            timer_next = '0;
        end else if (state == ST_ERROR) begin
            // Strobes other than clear are ignored while the error is shown.
            if (timer == '0) state_next = ST_IDLE;
            else             timer_next = timer - TMR_W'(1);
        end else if (err) begin
            state_next = ST_ERROR;
            cnt_next   = '0;
            buf_next   = '0;
            timer_next = TMR_LOAD;
        end else if (key_valid && (key_val <= CODE_W'(9)) &&
                     (press_count < CNT_W'(DIGITS))) begin
            buf_next[press_count[IDX_W-1:0]] = key_val;
            cnt_next   = press_count + CNT_W'(1);
            state_next = ST_ENTRY;
        end
    end

    // Entry, timer and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            press_count <= '0;
            digit_buf   <= '0;
            timer       <= '0;
            busy_err    <= 1'b0;
        end else begin
            press_count <= cnt_next;
            digit_buf   <= buf_next;
            timer       <= timer_next;
            busy_err    <= (state_next == ST_ERROR);
        end
    end

    // Free-running scan prescaler and slot index
    assign scan_tick_c = (presc == PRE_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= scan_tick_c ? '0 : presc + PRE_W'(1);
            if (scan_tick_c) idx <= idx + IDX_W'(1);
        end
    end

`ifdef DISP_BLINK_EN
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink;

    // Blink phase toggles every 256 slot advances, restarting on ERROR entry
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if ((state != ST_ERROR) && (state_next == ST_ERROR)) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if ((state == ST_ERROR) && scan_tick_c) begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
            if (blink_cnt == '1) blink <= ~blink;
        end
    end
`endif

    assign code_sel_c = (state == ST_ERROR) ? ERR_CODE : digit_buf[idx];

    seven_seg_decode u_decode (
        .code  (code_sel_c),
        .seg_c (seg_dec_c)
    );

    // Display selection for the current slot
    always_comb begin
        anode_next = BLANK_AN;
        seg_next   = BLANK_SEG;
        case (state)
            ST_ENTRY: begin
                if (CNT_W'(idx) < press_count) begin
                    anode_next = anode_sel(idx);
                    seg_next   = seg_dec_c;
                end
            end
            ST_ERROR: begin
                anode_next = anode_sel(idx);
                seg_next   = seg_dec_c;
`ifdef DISP_BLINK_EN
                if (blink) begin
                    anode_next = BLANK_AN;
                    seg_next   = BLANK_SEG;
                end
`endif
            end
            default: ;
        endcase
    end

    // Registered display outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            anode  <= BLANK_AN;
            segOut <= BLANK_SEG;
        end else begin
            anode  <= anode_next;
            segOut <= seg_next;
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl (REFRESH_DIV=4, ERR_CYCLES=50).
// A cycle-level reference model predicts every output after every edge;
// table vectors and directed sequences add fixed expectations.
module tb_disp_scan_ctrl;

    localparam int RD = 4;
    localparam int EC = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_val = 4'd0;
    logic       clear = 1'b0;
    logic       err = 1'b0;
    logic [2:0] press_count;
    logic       busy_err;
    logic [3:0] anode;
    logic [6:0] segOut;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: mode 0 idle, 1 entry, 2 error
    int m_mode, m_cnt, m_edges, m_err_end;
    int m_dig [4];

    disp_scan_ctrl #(.REFRESH_DIV(RD), .ERR_CYCLES(EC)) dut (
        .clk         (clk),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_val     (key_val),
        .clear       (clear),
        .err         (err),
        .press_count (press_count),
        .busy_err    (busy_err),
        .anode       (anode),
        .segOut      (segOut)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dec(input int v);
        case (v)
            0: return 7'b1000000;   1: return 7'b1111001;
            2: return 7'b0100100;   3: return 7'b0110000;
            4: return 7'b0011001;   5: return 7'b0010010;
            6: return 7'b0000010;   7: return 7'b1111000;
            8: return 7'b0000000;   9: return 7'b0010000;
            10: return 7'b0001001;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [3:0] an_for(input int slot);
        logic [3:0] a;
        a = 4'b1111;
        a[3 - slot] = 1'b0;
        return a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_clear();
        m_mode = 0; m_cnt = 0;
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
    endtask

    // One clock: predict from pre-edge model, advance model, compare after edge
    task automatic step();
        logic [3:0] ea;
        logic [6:0] es;
        int slot;
        ea = 4'b1111; es = 7'b1111111;
        if (!reset) begin
            slot = (m_edges / RD) % 4;
            if (m_mode == 2) begin
                ea = an_for(slot); es = dec(10);
            end else if (m_mode == 1 && slot < m_cnt) begin
                ea = an_for(slot); es = dec(m_dig[slot]);
            end
        end
        if (reset) begin
            model_clear(); m_edges = 0;
        end else begin
            m_edges++;
            if (clear) model_clear();
            else if (m_mode == 2) begin
                if (m_edges == m_err_end) m_mode = 0;
            end else if (err) begin
                model_clear(); m_mode = 2; m_err_end = m_edges + EC;
            end else if (key_valid && key_val <= 4'd9 && m_cnt < 4) begin
                m_dig[m_cnt] = int'(key_val); m_cnt++; m_mode = 1;
            end
        end
        @(posedge clk); #1;
        chk("model press_count", 32'(press_count), 32'(m_cnt));
        chk("model busy_err", 32'(busy_err), 32'(m_mode == 2));
        chk("model anode", 32'(anode), 32'(ea));
        chk("model segOut", 32'(segOut), 32'(es));
    endtask

    task automatic drive(input logic kv, input logic [3:0] kval, input logic clr, input logic er);
        key_valid = kv; key_val = kval; clear = clr; err = er;
    endtask

    task automatic do_reset();
        reset = 1'b1; drive(0, 0, 0, 0); step(); reset = 1'b0;
    endtask

    task automatic press(input logic [3:0] v);
        drive(1, v, 0, 0); step(); drive(0, 0, 0, 0);
    endtask

    typedef struct {
        logic       kv;
        logic [3:0] kval;
        logic       clr;
        logic       er;
        int         exp_cnt;
        logic       exp_busy;
    } vec_t;

    vec_t vecs [14];

    logic [3:0] exp_an  [4];
    logic [6:0] exp_seg [4];

    initial begin
        int busy_cycles, slot;
        logic [3:0] seen;
        logic found;

        vecs[0]  = '{1'b1, 4'd1,  1'b0, 1'b0, 1, 1'b0};
        vecs[1]  = '{1'b1, 4'd2,  1'b0, 1'b0, 2, 1'b0};
        vecs[2]  = '{1'b1, 4'd3,  1'b0, 1'b0, 3, 1'b0};
        vecs[3]  = '{1'b1, 4'hC,  1'b0, 1'b0, 3, 1'b0};
        vecs[4]  = '{1'b1, 4'd4,  1'b0, 1'b0, 4, 1'b0};
        vecs[5]  = '{1'b1, 4'd5,  1'b0, 1'b0, 4, 1'b0};
        vecs[6]  = '{1'b1, 4'd7,  1'b0, 1'b1, 0, 1'b1};
        vecs[7]  = '{1'b1, 4'd7,  1'b0, 1'b0, 0, 1'b1};
        vecs[8]  = '{1'b0, 4'd0,  1'b0, 1'b1, 0, 1'b1};
        vecs[9]  = '{1'b0, 4'd0,  1'b1, 1'b0, 0, 1'b0};
        vecs[10] = '{1'b1, 4'd9,  1'b0, 1'b0, 1, 1'b0};
        vecs[11] = '{1'b1, 4'd2,  1'b1, 1'b1, 0, 1'b0};
        vecs[12] = '{1'b0, 4'd0,  1'b0, 1'b1, 0, 1'b1};
        vecs[13] = '{1'b0, 4'd0,  1'b1, 1'b0, 0, 1'b0};

        exp_an[0] = 4'b0111; exp_seg[0] = 7'b1111001;
        exp_an[1] = 4'b1011; exp_seg[1] = 7'b0100100;
        exp_an[2] = 4'b1101; exp_seg[2] = 7'b0110000;
        exp_an[3] = 4'b1111; exp_seg[3] = 7'b1111111;

        m_edges = 0; m_err_end = 0;
        model_clear();

        // Reset values
        do_reset();
        chk("reset anode", 32'(anode), 32'h0000000F);
        chk("reset segOut", 32'(segOut), 32'h0000007F);
        chk("reset busy_err", 32'(busy_err), 32'd0);
        chk("reset press_count", 32'(press_count), 32'd0);

        // Keys 1,2,3 then one full scan rotation
        press(4'd1); press(4'd2); press(4'd3);
        chk("three keys count", 32'(press_count), 32'd3);
        for (int e = 4; e < 20; e++) begin
            step();
            if (e % 4 == 1) begin
                slot = ((e - 1) / RD) % 4;
                chk("scan anode", 32'(anode), 32'(exp_an[slot]));
                chk("scan segOut", 32'(segOut), 32'(exp_seg[slot]));
            end
        end

        // Five keys: fifth ignored, last slot holds 6
        do_reset();
        press(4'd9); press(4'd8); press(4'd7); press(4'd6); press(4'd5);
        chk("full count", 32'(press_count), 32'd4);
        found = 1'b0;
        for (int i = 0; i < 32 && !found; i++) begin
            step();
            if (anode == 4'b1110) found = 1'b1;
        end
        chk("slot3 reached", 32'(found), 32'd1);
        chk("slot3 digit", 32'(segOut), 32'(7'b0000010));

        // Illegal key value ignored
        do_reset();
        press(4'd4); press(4'hC);
        chk("illegal key count", 32'(press_count), 32'd1);

        // Error hold time and glyph on every slot
        do_reset();
        press(4'd5);
        drive(0, 0, 0, 1); step(); drive(0, 0, 0, 0);
        busy_cycles = busy_err ? 1 : 0;
        seen = 4'b0000;
        for (int i = 0; i < 100; i++) begin
            if (segOut == 7'b0001001) seen = seen | ~anode;
            step();
            if (!busy_err) break;
            busy_cycles++;
        end
        chk("error duration", 32'(busy_cycles), 32'(EC));
        chk("error all slots", 32'(seen), 32'h0000000F);
        step();
        chk("post error anode", 32'(anode), 32'h0000000F);

        // Table vectors
        do_reset();
        for (int v = 0; v < 14; v++) begin
            drive(vecs[v].kv, vecs[v].kval, vecs[v].clr, vecs[v].er);
            step();
            chk($sformatf("vec%0d press_count", v), 32'(press_count), 32'(vecs[v].exp_cnt));
            chk($sformatf("vec%0d busy_err", v), 32'(busy_err), 32'(vecs[v].exp_busy));
        end
        drive(0, 0, 0, 0);

        // Reset in the middle of an error
        press(4'd3);
        drive(0, 0, 0, 1); step(); drive(0, 0, 0, 0);
        repeat (7) step();
        reset = 1'b1; drive(1, 4'd2, 0, 1);
        step();
        reset = 1'b0; drive(0, 0, 0, 0);
        chk("midreset anode", 32'(anode), 32'h0000000F);
        chk("midreset segOut", 32'(segOut), 32'h0000007F);
        chk("midreset busy_err", 32'(busy_err), 32'd0);
        chk("midreset press_count", 32'(press_count), 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 499) == 0);
            key_valid = ($urandom_range(0, 2) == 0);
            key_val   = 4'($urandom_range(0, 15));
            clear     = ($urandom_range(0, 59) == 0);
            err       = ($urandom_range(0, 39) == 0);
            step();
        end
        reset = 1'b0; drive(0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
